image_stream_gen: RTL and testbench

Video stream source that drives the `pre_frame_*` pixel-stream interface consumed by the image-processing blocks, such as the median, Sobel and binarisation filters. It owns the frame timing: per-pixel `valid`, line-active `hsync`, and a frame-start `vsync` pulse. It pulls 8-bit luma from an upstream valid/ready source, for example a frame-buffer read FIFO. It is the transmitter end of the stream interface, used both in the processing chain and as a bench/bring-up pattern source.

---
 rtl/image_stream_gen_pkg.sv | 27 ++
 rtl/image_stream_gen_if.sv | 34 +++
 rtl/image_stream_gen_timing_cnt.sv | 68 ++++++
 rtl/image_stream_gen.sv | 150 +++++++++++++++
 tb/tb_image_stream_gen.sv | 292 +++++++++++++++++++++++++++++
 5 files changed

// File: rtl/image_stream_gen_pkg.sv
// Shared definitions for the image-processing stream blocks: default frame timing,
// the luma pixel type, the generator FSM states and small width/wrap helpers.
package image_proc_pkg;

    localparam int H_ACTIVE_DEF = 640;
    localparam int H_BLANK_DEF  = 160;
    localparam int V_ACTIVE_DEF = 480;
    localparam int V_BLANK_DEF  = 45;
    localparam int VS_LINES_DEF = 2;

    typedef logic [7:0] pixel_t;

    typedef enum logic {
        IDLE = 1'b0,
        RUN  = 1'b1
    } gen_state_e;

    // Counter width for a modulus n, never narrower than one bit.
    function automatic int cnt_w(int n);
        return (n < 2) ? 1 : $clog2(n);
    endfunction

    function automatic pixel_t wrap_pix(int x);
        return pixel_t'(x);
    endfunction

endpackage

// File: rtl/image_stream_gen_if.sv
// Pixel stream bundle: upstream valid/ready luma source plus the pre_frame_* output stream.
// master = generator side, slave = the upstream source / downstream filter side.
interface image_stream_gen_if;
    import image_proc_pkg::*;

    logic   src_valid;
    pixel_t src_data;
    logic   src_ready;
    logic   pre_frame_vsync;
    logic   pre_frame_hsync;
    logic   pre_frame_valid;
    pixel_t pre_img_y;

    modport master (
        input  src_valid,
        input  src_data,
        output src_ready,
        output pre_frame_vsync,
        output pre_frame_hsync,
        output pre_frame_valid,
        output pre_img_y
    );

    modport slave (
        output src_valid,
        output src_data,
        input  src_ready,
        input  pre_frame_vsync,
        input  pre_frame_hsync,
        input  pre_frame_valid,
        input  pre_img_y
    );

endinterface

// File: rtl/image_stream_gen_timing_cnt.sv
// Horizontal/vertical slot counters with active, vsync, last-slot and frame-start decode.
// Counters advance every cycle while run_i is high and sit at 0/0 otherwise.
module video_timing_cnt
    import image_proc_pkg::*;
#(
    parameter int H_ACTIVE = H_ACTIVE_DEF,
    parameter int H_BLANK  = H_BLANK_DEF,
    parameter int V_ACTIVE = V_ACTIVE_DEF,
    parameter int V_BLANK  = V_BLANK_DEF,
    parameter int VS_LINES = VS_LINES_DEF
) (
    input  logic                                        clk,
    input  logic                                        rst,
    input  logic                                        run_i,
    output logic [cnt_w(H_ACTIVE + H_BLANK)-1:0]        h_cnt_o,
    output logic [cnt_w(V_BLANK + V_ACTIVE)-1:0]        v_cnt_o,
    output logic                                        active_o,
    output logic                                        vsync_o,
    output logic                                        last_o,
    output logic                                        frame_start_o
);

    localparam int H_TOTAL = H_ACTIVE + H_BLANK;
    localparam int V_TOTAL = V_BLANK + V_ACTIVE;
    localparam int HW      = cnt_w(H_TOTAL);
    localparam int VW      = cnt_w(V_TOTAL);

    logic [HW-1:0] h_q, h_d;
    logic [VW-1:0] v_q, v_d;
    logic          h_last;
    logic          v_last;

    assign h_last = (h_q == HW'(H_TOTAL - 1));
    assign v_last = (v_q == VW'(V_TOTAL - 1));

    always_comb begin
        h_d = h_q;
        v_d = v_q;
        if (!run_i) begin
            h_d = '0;
            v_d = '0;
        end else if (h_last) begin
            h_d = '0;
            v_d = v_last ? '0 : v_q + VW'(1);
        end else begin
            h_d = h_q + HW'(1);
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            h_q <= '0;
            v_q <= '0;
        end else begin
            h_q <= h_d;
            v_q <= v_d;
        end
    end

    // v_q never reaches V_TOTAL, so only the lower bound matters for active lines.
    assign active_o      = (v_q >= VW'(V_BLANK)) && (h_q < HW'(H_ACTIVE));
    assign vsync_o       = (v_q < VW'(VS_LINES));
    assign last_o        = h_last && v_last;
    assign frame_start_o = (h_q == '0) && (v_q == '0);
    assign h_cnt_o       = h_q;
    assign v_cnt_o       = v_q;

endmodule

// File: rtl/image_stream_gen.sv
// Rigid-timing video source: IDLE/RUN FSM, upstream pull, registered pre_frame_* outputs.
// Optional diagonal test pattern when IMAGE_STREAM_GEN_PATTERN_EN is defined.
module image_stream_gen
    import image_proc_pkg::*;
#(
    parameter int H_ACTIVE = H_ACTIVE_DEF,
    parameter int H_BLANK  = H_BLANK_DEF,
    parameter int V_ACTIVE = V_ACTIVE_DEF,
    parameter int V_BLANK  = V_BLANK_DEF,
    parameter int VS_LINES = VS_LINES_DEF
) (
    input  logic                      clk,
    input  logic                      rst,
    input  logic                      enable,
    input  logic                      pattern_sel,
    image_stream_gen_if.master        sif,
    output logic                      frame_done,
    output logic                      busy,
    output logic                      underflow
);

    localparam int H_TOTAL = H_ACTIVE + H_BLANK;
    localparam int V_TOTAL = V_BLANK + V_ACTIVE;

    gen_state_e state_q, state_d;

    logic [cnt_w(H_TOTAL)-1:0] h_cnt;
    logic [cnt_w(V_TOTAL)-1:0] v_cnt;
    logic                      slot_active;
    logic                      slot_vsync;
    logic                      slot_last;
    logic                      slot_start;
    logic                      run;

    logic   vsync_q, vsync_d;
    logic   hsync_q, hsync_d;
    logic   valid_q, valid_d;
    pixel_t y_q, y_d;
    logic   done_q, done_d;
    logic   under_q, under_d;
    logic   src_take;

    logic   pattern_mode;
    pixel_t pat_pix;

    assign run = (state_q == RUN);

    video_timing_cnt #(
        .H_ACTIVE (H_ACTIVE),
        .H_BLANK  (H_BLANK),
        .V_ACTIVE (V_ACTIVE),
        .V_BLANK  (V_BLANK),
        .VS_LINES (VS_LINES)
    ) u_timing (
        .clk           (clk),
        .rst           (rst),
        .run_i         (run),
        .h_cnt_o       (h_cnt),
        .v_cnt_o       (v_cnt),
        .active_o      (slot_active),
        .vsync_o       (slot_vsync),
        .last_o        (slot_last),
        .frame_start_o (slot_start)
    );

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // enable only matters in IDLE or on the final slot, so a frame is never cut short.
    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE:    if (enable) state_d = RUN;
            RUN:     if (slot_last && !enable) state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

`ifdef IMAGE_STREAM_GEN_PATTERN_EN
    logic pat_q, pat_d;

    always_comb begin
        pat_d = pat_q;
        if (run && slot_start) pat_d = pattern_sel;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            pat_q <= 1'b0;
        end else begin
            pat_q <= pat_d;
        end
    end

    assign pattern_mode = pat_q;
    assign pat_pix      = wrap_pix(int'(h_cnt) + int'(v_cnt) - V_BLANK);
`else
    logic unused_pattern_inputs;

    assign unused_pattern_inputs = ^{pattern_sel, h_cnt, v_cnt};
    assign pattern_mode          = 1'b0;
    assign pat_pix               = '0;
`endif

    always_comb begin
        src_take = run && slot_active && !pattern_mode;
        vsync_d  = run && slot_vsync;
        hsync_d  = run && slot_active;
        valid_d  = hsync_d && (pattern_mode || sif.src_valid);
        y_d      = '0;
        if (valid_d) y_d = pattern_mode ? pat_pix : sif.src_data;
        done_d   = run && slot_last;
        // Clear at frame start, but a starved slot in the same cycle still sets.
        under_d  = (run && slot_start) ? 1'b0 : under_q;
        if (src_take && !sif.src_valid) under_d = 1'b1;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            vsync_q <= 1'b0;
            hsync_q <= 1'b0;
            valid_q <= 1'b0;
            y_q     <= '0;
            done_q  <= 1'b0;
            under_q <= 1'b0;
        end else begin
            vsync_q <= vsync_d;
            hsync_q <= hsync_d;
            valid_q <= valid_d;
            y_q     <= y_d;
            done_q  <= done_d;
            under_q <= under_d;
        end
    end

    assign sif.src_ready       = src_take;
    assign sif.pre_frame_vsync = vsync_q;
    assign sif.pre_frame_hsync = hsync_q;
    assign sif.pre_frame_valid = valid_q;
    assign sif.pre_img_y       = y_q;
    assign frame_done          = done_q;
    assign busy                = (state_q != IDLE);
    assign underflow           = under_q;

endmodule

// File: tb/tb_image_stream_gen.sv
// Bench for image_stream_gen on a 6x5-slot frame: directed tables and sequences,
// then random traffic, all against a slot-position reference model.
`timescale 1ns/1ps
module tb_image_stream_gen;
    import image_proc_pkg::*;

    localparam int HA = 4;
    localparam int HB = 2;
    localparam int VA = 3;
    localparam int VB = 2;
    localparam int VS = 1;
    localparam int HT = HA + HB;
    localparam int VT = VB + VA;
    localparam int FR = HT * VT;
`ifdef IMAGE_STREAM_GEN_PATTERN_EN
    localparam bit PAT_EN = 1'b1;
`else
    localparam bit PAT_EN = 1'b0;
`endif

    logic clk = 1'b0;
    logic rst, enable, pattern_sel;
    logic frame_done, busy, underflow;

    image_stream_gen_if sif();

    image_stream_gen #(
        .H_ACTIVE (HA),
        .H_BLANK  (HB),
        .V_ACTIVE (VA),
        .V_BLANK  (VB),
        .VS_LINES (VS)
    ) dut (
        .clk         (clk),
        .rst         (rst),
        .enable      (enable),
        .pattern_sel (pattern_sel),
        .sif         (sif),
        .frame_done  (frame_done),
        .busy        (busy),
        .underflow   (underflow)
    );

    always #5 clk = ~clk;

    int n_cmp = 0;
    int n_bad = 0;
    int cyc   = 0;
    bit cnt_mode = 1'b0;

    // Reference model: generator position as a flat slot index within the frame.
    bit         m_run = 1'b0;
    int         m_pos = 0;
    bit         m_under = 1'b0;
    bit         m_pat = 1'b0;
    bit         e_vs, e_hs, e_vld, e_fd;
    logic [7:0] e_y;

    typedef struct {
        int         cyc;
        bit         vs;
        bit         hs;
        bit         vld;
        bit         fd;
        bit         bsy;
        logic [7:0] y;
    } vec_t;

    vec_t vecs[15];

    task automatic chk(string nm, logic [31:0] act, logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s cyc=%0d got=%0d want=%0d", nm, cyc, act, exp);
        end
    endtask

    function automatic bit slot_act(int pos);
        return ((pos / HT) >= VB) && ((pos % HT) < HA);
    endfunction

    task automatic model_step();
        int row, col;
        bit act, last, pv;
        if (rst) begin
            m_run = 1'b0; m_pos = 0; m_under = 1'b0; m_pat = 1'b0;
            e_vs = 1'b0; e_hs = 1'b0; e_vld = 1'b0; e_fd = 1'b0; e_y = 8'd0;
        end else if (!m_run) begin
            e_vs = 1'b0; e_hs = 1'b0; e_vld = 1'b0; e_fd = 1'b0; e_y = 8'd0;
            if (enable) begin
                m_run = 1'b1;
                m_pos = 0;
            end
        end else begin
            row  = m_pos / HT;
            col  = m_pos % HT;
            act  = (row >= VB) && (col < HA);
            last = (m_pos == FR - 1);
            if (m_pos == 0) begin
                m_pat   = PAT_EN && pattern_sel;
                m_under = 1'b0;
            end
            pv    = act && (m_pat || sif.src_valid);
            e_vs  = (row < VS);
            e_hs  = act;
            e_vld = pv;
            if (!pv)        e_y = 8'd0;
            else if (m_pat) e_y = 8'((row + col - VB) & 255);
            else            e_y = sif.src_data;
            if (act && !m_pat && !sif.src_valid) m_under = 1'b1;
            e_fd = last;
            if (last) begin
                m_pos = 0;
                if (!enable) m_run = 1'b0;
            end else begin
                m_pos++;
            end
        end
    endtask

    task automatic tick();
        bit acc;
        acc = m_run && slot_act(m_pos) && !m_pat && sif.src_valid;
        model_step();
        @(posedge clk);
        @(negedge clk);
        cyc++;
        chk("vsync",     sif.pre_frame_vsync, e_vs);
        chk("hsync",     sif.pre_frame_hsync, e_hs);
        chk("valid",     sif.pre_frame_valid, e_vld);
        chk("pre_img_y", sif.pre_img_y, e_y);
        chk("frame_done", frame_done, e_fd);
        chk("busy",      busy, m_run);
        chk("underflow", underflow, m_under);
        chk("src_ready", sif.src_ready, m_run && slot_act(m_pos) && !m_pat);
        if (cnt_mode && acc) sif.src_data = sif.src_data + 8'd1;
    endtask

    initial begin
        logic [7:0] exp_line[8];
        int nv, nfd, nvs_after, busy_at_fd, prev;
        int rises[$];
        bit seen_fd;

        vecs[0]  = '{0,  1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 8'd0};
        vecs[1]  = '{1,  1'b1, 1'b0, 1'b0, 1'b0, 1'b1, 8'd0};
        vecs[2]  = '{6,  1'b1, 1'b0, 1'b0, 1'b0, 1'b1, 8'd0};
        vecs[3]  = '{7,  1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 8'd0};
        vecs[4]  = '{12, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 8'd0};
        vecs[5]  = '{13, 1'b0, 1'b1, 1'b1, 1'b0, 1'b1, 8'd0};
        vecs[6]  = '{16, 1'b0, 1'b1, 1'b1, 1'b0, 1'b1, 8'd3};
        vecs[7]  = '{17, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 8'd0};
        vecs[8]  = '{19, 1'b0, 1'b1, 1'b1, 1'b0, 1'b1, 8'd4};
        vecs[9]  = '{22, 1'b0, 1'b1, 1'b1, 1'b0, 1'b1, 8'd7};
        vecs[10] = '{25, 1'b0, 1'b1, 1'b1, 1'b0, 1'b1, 8'd8};
        vecs[11] = '{28, 1'b0, 1'b1, 1'b1, 1'b0, 1'b1, 8'd11};
        vecs[12] = '{29, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 8'd0};
        vecs[13] = '{30, 1'b0, 1'b0, 1'b0, 1'b1, 1'b1, 8'd0};
        vecs[14] = '{31, 1'b1, 1'b0, 1'b0, 1'b0, 1'b1, 8'd0};

`ifdef IMAGE_STREAM_GEN_PATTERN_EN
        exp_line = '{8'd0, 8'd1, 8'd2, 8'd3, 8'd1, 8'd2, 8'd3, 8'd4};
`else
        exp_line = '{8'd0, 8'd1, 8'd2, 8'd3, 8'd4, 8'd5, 8'd6, 8'd7};
`endif

        rst = 1'b1; enable = 1'b0; pattern_sel = 1'b0;
        sif.src_valid = 1'b0; sif.src_data = 8'd0;
        @(negedge clk);
        repeat (3) tick();
        rst = 1'b0;
        tick();

        // First frame from reset, counting source data, checked against the table.
        cnt_mode = 1'b1; sif.src_data = 8'd0; sif.src_valid = 1'b1; enable = 1'b1;
        tick();
        for (int c = 0; c <= 31; c++) begin
            foreach (vecs[i]) begin
                if (vecs[i].cyc == c) begin
                    chk("t_vsync", sif.pre_frame_vsync, vecs[i].vs);
                    chk("t_hsync", sif.pre_frame_hsync, vecs[i].hs);
                    chk("t_valid", sif.pre_frame_valid, vecs[i].vld);
                    chk("t_fdone", frame_done, vecs[i].fd);
                    chk("t_busy",  busy, vecs[i].bsy);
                    chk("t_y",     sif.pre_img_y, vecs[i].y);
                end
            end
            tick();
        end

        // Drop enable mid-frame: the frame still completes exactly once.
        for (int k = 0; k < 40 && m_pos != 10; k++) tick();
        enable = 1'b0;
        nv = 0; nfd = 0; nvs_after = 0; busy_at_fd = -1; seen_fd = 1'b0;
        for (int k = 0; k < 40; k++) begin
            tick();
            if (sif.pre_frame_valid) nv++;
            if (seen_fd && sif.pre_frame_vsync) nvs_after++;
            if (frame_done) begin
                nfd++;
                busy_at_fd = busy;
                seen_fd = 1'b1;
            end
        end
        chk("drop_valid_cnt", nv, 12);
        chk("drop_fd_cnt", nfd, 1);
        chk("drop_busy_after", busy_at_fd, 0);
        chk("drop_vsync_after", nvs_after, 0);

        // Starve the second active slot of the first active line.
        enable = 1'b1;
        tick();
        for (int k = 0; k < 40 && m_pos != 13; k++) tick();
        sif.src_valid = 1'b0;
        tick();
        chk("uf_hsync", sif.pre_frame_hsync, 1);
        chk("uf_valid", sif.pre_frame_valid, 0);
        chk("uf_y", sif.pre_img_y, 0);
        chk("uf_flag", underflow, 1);
        sif.src_valid = 1'b1;
        for (int k = 0; k < 40 && m_pos != 0; k++) tick();
        chk("uf_held", underflow, 1);
        tick();
        chk("uf_cleared", underflow, 0);

        // Reset in the middle of a frame, then a clean restart.
        for (int k = 0; k < 40 && m_pos != 15; k++) tick();
        rst = 1'b1;
        tick();
        chk("rst_vsync", sif.pre_frame_vsync, 0);
        chk("rst_hsync", sif.pre_frame_hsync, 0);
        chk("rst_valid", sif.pre_frame_valid, 0);
        chk("rst_fd", frame_done, 0);
        chk("rst_busy", busy, 0);
        rst = 1'b0;
        tick();
        nv = 0; nfd = 0;
        for (int k = 1; k <= 30; k++) begin
            tick();
            if (k == 1) chk("restart_vsync", sif.pre_frame_vsync, 1);
            if (sif.pre_frame_valid) nv++;
            if (frame_done) begin
                nfd++;
                chk("restart_fd_pos", k, 30);
            end
        end
        chk("restart_valid_cnt", nv, 12);
        chk("restart_fd_cnt", nfd, 1);

        // Three continuous frames: vsync period and pixel count.
        nv = 0;
        prev = sif.pre_frame_vsync;
        for (int k = 1; k <= 90; k++) begin
            tick();
            if (sif.pre_frame_valid) nv++;
            if (sif.pre_frame_vsync && prev == 0) rises.push_back(cyc);
            prev = sif.pre_frame_vsync;
        end
        chk("cont_valid_cnt", nv, 36);
        chk("cont_rises", rises.size(), 3);
        for (int i = 1; i < rises.size(); i++) chk("cont_period", rises[i] - rises[i-1], FR);

        // pattern_sel high: gradient when built in, otherwise ignored.
        enable = 1'b0;
        for (int k = 0; k < 40 && m_run; k++) tick();
        chk("idle_busy", busy, 0);
        pattern_sel = 1'b1; sif.src_data = 8'd0; enable = 1'b1;
        tick();
        for (int c = 1; c <= 22; c++) begin
            tick();
            if (c >= 13 && c <= 16) chk("line_y", sif.pre_img_y, exp_line[c-13]);
            if (c >= 19 && c <= 22) chk("line_y", sif.pre_img_y, exp_line[c-15]);
        end
        pattern_sel = 1'b0;

        // Random traffic against the model.
        cnt_mode = 1'b0;
        for (int k = 0; k < 2000; k++) begin
            enable        = ($urandom % 16) != 0;
            sif.src_valid = ($urandom % 4) != 0;
            sif.src_data  = 8'($urandom);
            pattern_sel   = $urandom % 2;
            rst           = ($urandom % 400) == 0;
            tick();
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
